seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Receive-side decoder for the multiplexed four-digit seven-segment bus (`OL` segments plus one-hot `DIG` strobe) that the display driver produces. It samples the bus on every clock and rebuilds the four displayed digits as BCD. It checks that the scan order and segment patterns are legal, and after each complete scan it produces the displayed number in binary. It sits on the same `clk_16k` domain as the display driver and is used for on-board self-check and loopback of displayed values.

## Interface
- No parameters.
- `clk_16k` input 1: system scan clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `OL` input 7: segment pattern, bit 6 = seg a … bit 0 = seg g, active-high.
- `DIG` input 4: digit strobe; 1000 = thousands, 0100 = hundreds, 0010 = tens, 0001 = units.
- `bcd` output 16: last completed frame; [15:12] thousands … [3:0] units.
- `value` output 14: binary value of last frame with `frame_ok`=1; range 0–9999.
- `frame_valid` output 1: one-cycle pulse per completed frame.
- `frame_ok` output 1: qualifies `frame_valid`; 1 = all four digits decimal.
- `seg_err` output 1: sticky; an unrecognised segment pattern was seen.
- `seq_err` output 1: sticky; the strobe order was violated.

## Operation
- **Stage 0, input register.** `OL` and `DIG` are registered on every edge.
- **Stage 1, decode.**
  - Only one-hot `DIG` cycles are processed. For `DIG`=0000 or any multi-bit value, the cycle is ignored: no state change, no error.
  - Segment map:
    - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
    - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
    - 0000000→4'hF (blank)
    - anything else → 4'hE and sets `seg_err`.
- **Sequence FSM** (states WAIT, TH, HU, TE):
  - WAIT: strobe 1000 → store thousands, go to TH. Any other strobe → stay in WAIT, no error (this is how the block acquires the frame).
  - TH: 1000 → overwrite thousands, stay. 0100 → store hundreds, go to HU.
  - HU: 0100 → overwrite, stay. 0010 → store tens, go to TE.
  - TE: 0010 → overwrite, stay. 0001 → store units, frame complete, go to WAIT.
  - In TH/HU/TE, any other one-hot strobe sets `seq_err` and discards the partial frame. If that strobe is 1000, go to TH with thousands stored; otherwise go to WAIT.
  - Repeated strobes are not errors, so drivers scanning slower than `clk_16k` are supported.
  - Units repeated while in WAIT are ignored. One frame is produced per scan.
- **Stage 2, output.** On frame complete:
  - `bcd` is loaded with the four digit codes and `frame_valid` pulses.
  - `frame_ok` = 1 only if every code ≤ 9.
  - If `frame_ok`, `value` = th·1000 + hu·100 + te·10 + un, computed in 14-bit unsigned. The result cannot overflow; maximum is 9999.
  - If not `frame_ok`, `value` holds its previous contents.
- **Flag persistence.** `seg_err` and `seq_err` clear only on `rst`. `frame_ok` holds until the next `frame_valid`.

## Timing
- Reset values: `bcd`=0, `value`=0, `frame_valid`=0, `frame_ok`=0, `seg_err`=0, `seq_err`=0, FSM=WAIT, input registers=0.
- Latency: the units digit present on the pins before edge k gives `frame_valid`=1, with `bcd`/`value`/`frame_ok` updated, in the cycle after edge k+2. The pulse is exactly one cycle wide.
- Minimum frame period: 4 cycles, matching a driver with one digit per clock. Back-to-back frames produce pulses 4 cycles apart.
- `rst` mid-frame: the partial frame is discarded, no `frame_valid` is issued, the pipeline registers are cleared, and the next frame must start with a thousands strobe.
- A `seg_err` pattern on a digit still advances the FSM. The resulting frame completes with `frame_ok`=0.
- `seq_err` asserts in the cycle after stage 1 detects the violation.

## Test plan
- **Good frame.** Strobes 1000/1111110, 0100/1101101, 0010/1011011, 0001/1011011, one per clock → single `frame_valid` 2 cycles after the units sample. Expect `bcd`=16'h0255, `value`=255, `frame_ok`=1, no errors.
- **Slow scan at maximum value.** Each digit of 9999 held for 3 cycles, repeated for two scans → exactly two `frame_valid` pulses, `value`=9999, `seq_err`=0.
- **Order violation.** Strobes 1000, then 0010 → `seq_err`=1, no frame. A following good frame 0,1,2,3 → `value`=123, `seq_err` stays 1.
- **Bad segment.** Tens pattern 1010101 in a frame 4,5,?,6 → `seg_err`=1, `frame_valid` with `frame_ok`=0, `bcd`[7:4]=4'hE, `value` unchanged from the prior frame.
- **Illegal strobes.** `DIG`=0000 and 0011 cycles inserted between each digit of 8,0,7,1 → ignored, `value`=8071, no errors.
- **Reset mid-frame.** `rst` one cycle after the hundreds sample → no `frame_valid`, all outputs 0. Units alone then gives no frame; the next full scan 0,0,4,2 → `value`=42.

Source files
------------

// File: rtl/seg_scan_capture_if.sv
// Seven-segment scan bus seen from the display side, plus the decoded frame results.
// Purely combinational bundle; no latency of its own.
// No backpressure: the scan bus is sampled every clock, results are pulse-qualified.
interface seg_scan_capture_if;
  logic [6:0]  OL;
  logic [3:0]  DIG;
  logic [15:0] bcd;
  logic [13:0] value;
  logic        frame_valid;
  logic        frame_ok;
  logic        seg_err;
  logic        seq_err;

  // Driver / bus-model side: produces the scan bus, observes the decoded results.
  modport master (
    output OL, DIG,
    input  bcd, value, frame_valid, frame_ok, seg_err, seq_err
  );

  // Capture side: samples the scan bus, produces the decoded results.
  modport slave (
    input  OL, DIG,
    output bcd, value, frame_valid, frame_ok, seg_err, seq_err
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Rebuilds the 4-digit BCD number from a multiplexed 7-seg scan bus and checks scan order.
// Latency: units digit on the pins before edge k -> frame_valid high after edge k+2.
// No backpressure: one frame per complete scan, results held until the next frame.
module seg_scan_capture (
  input logic              clk_16k,
  input logic              rst,
  seg_scan_capture_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_TH   = 2'd1,
    ST_HU   = 2'd2,
    ST_TE   = 2'd3
  } state_t;

  localparam logic [3:0] DIG_TH = 4'b1000;
  localparam logic [3:0] DIG_HU = 4'b0100;
  localparam logic [3:0] DIG_TE = 4'b0010;
  localparam logic [3:0] DIG_UN = 4'b0001;

  // Stage 0 input registers
  logic [6:0]  ol_q, ol_d;
  logic [3:0]  dig_q, dig_d;

  // Stage 1 sequencing state and partial frame
  state_t      state_q, state_d;
  logic [3:0]  th_q, th_d;
  logic [3:0]  hu_q, hu_d;
  logic [3:0]  te_q, te_d;
  logic [15:0] frame_q, frame_d;
  logic        done_q, done_d;
  logic        seg_err_q, seg_err_d;
  logic        seq_err_q, seq_err_d;

  // Stage 2 output registers
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] value_q, value_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_ok_q, frame_ok_d;

  logic [3:0]  code;
  logic        code_bad;
  logic        one_hot;
  logic        frame_dec;
  logic [13:0] value_calc;

  // Segment decode of the registered pattern, and strobe qualification.
  always_comb begin
    code_bad = 1'b0;
    case (ol_q)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b1011111: code = 4'd6;
      7'b1110000: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1111011: code = 4'd9;
      7'b0000000: code = 4'hF;
      default: begin
        code     = 4'hE;
        code_bad = 1'b1;
      end
    endcase
    one_hot = (dig_q == DIG_TH) || (dig_q == DIG_HU) ||
              (dig_q == DIG_TE) || (dig_q == DIG_UN);
  end

  // Scan-order FSM: collects digits in thousands..units order, flags order violations.
  always_comb begin
    ol_d      = bus.OL;
    dig_d     = bus.DIG;
    state_d   = state_q;
    th_d      = th_q;
    hu_d      = hu_q;
    te_d      = te_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    seq_err_d = seq_err_q;
    seg_err_d = seg_err_q | (one_hot & code_bad);

    if (one_hot) begin
      case (state_q)
        ST_WAIT: begin
          // Anything but a thousands strobe is just frame acquisition.
          if (dig_q == DIG_TH) begin
            th_d    = code;
            state_d = ST_TH;
          end
        end
        ST_TH: begin
          if (dig_q == DIG_TH) begin
            th_d = code;
          end else if (dig_q == DIG_HU) begin
            hu_d    = code;
            state_d = ST_HU;
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
        ST_HU: begin
          if (dig_q == DIG_HU) begin
            hu_d = code;
          end else if (dig_q == DIG_TE) begin
            te_d    = code;
            state_d = ST_TE;
          end else if (dig_q == DIG_TH) begin
            // Out-of-order thousands restarts a fresh frame.
            seq_err_d = 1'b1;
            th_d      = code;
            state_d   = ST_TH;
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
        ST_TE: begin
          if (dig_q == DIG_TE) begin
            te_d = code;
          end else if (dig_q == DIG_UN) begin
            frame_d = {th_q, hu_q, te_q, code};
            done_d  = 1'b1;
            state_d = ST_WAIT;
          end else if (dig_q == DIG_TH) begin
            seq_err_d = 1'b1;
            th_d      = code;
            state_d   = ST_TH;
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Output stage: publish the completed frame and its binary value when all digits are decimal.
  always_comb begin
    frame_dec = (frame_q[15:12] <= 4'd9) && (frame_q[11:8] <= 4'd9) &&
                (frame_q[7:4]   <= 4'd9) && (frame_q[3:0]  <= 4'd9);
    value_calc = 14'(frame_q[15:12]) * 14'd1000 +
                 14'(frame_q[11:8])  * 14'd100  +
                 14'(frame_q[7:4])   * 14'd10   +
                 14'(frame_q[3:0]);
    frame_valid_d = done_q;
    bcd_d         = bcd_q;
    frame_ok_d    = frame_ok_q;
    value_d       = value_q;
    if (done_q) begin
      bcd_d      = frame_q;
      frame_ok_d = frame_dec;
      if (frame_dec) begin
        value_d = value_calc;
      end
    end
  end

  // All pipeline state; reset clears everything, including any partial frame.
  always_ff @(posedge clk_16k) begin
    if (rst) begin
      ol_q          <= '0;
      dig_q         <= '0;
      state_q       <= ST_WAIT;
      th_q          <= '0;
      hu_q          <= '0;
      te_q          <= '0;
      frame_q       <= '0;
      done_q        <= 1'b0;
      seg_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      bcd_q         <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_ok_q    <= 1'b0;
    end else begin
      ol_q          <= ol_d;
      dig_q         <= dig_d;
      state_q       <= state_d;
      th_q          <= th_d;
      hu_q          <= hu_d;
      te_q          <= te_d;
      frame_q       <= frame_d;
      done_q        <= done_d;
      seg_err_q     <= seg_err_d;
      seq_err_q     <= seq_err_d;
      bcd_q         <= bcd_d;
      value_q       <= value_d;
      frame_valid_q <= frame_valid_d;
      frame_ok_q    <= frame_ok_d;
    end
  end

  assign bus.bcd         = bcd_q;
  assign bus.value       = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: frames are predicted when their units digit is driven.
// Expected frame_valid arrives 3 cycle counts after the units digit is driven.
// The scan bus has no backpressure; the monitor checks every frame_valid pulse.
module tb_seg_scan_capture;

  logic clk_16k = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   mdl_value = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] value;
    logic        ok;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  seg_scan_capture_if bus ();

  seg_scan_capture dut (
    .clk_16k (clk_16k),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_16k = ~clk_16k;

  // Count rising edges for latency checking.
  always @(posedge clk_16k) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:  seg_of = 7'b1111110;
      1:  seg_of = 7'b0110000;
      2:  seg_of = 7'b1101101;
      3:  seg_of = 7'b1111001;
      4:  seg_of = 7'b0110011;
      5:  seg_of = 7'b1011011;
      6:  seg_of = 7'b1011111;
      7:  seg_of = 7'b1110000;
      8:  seg_of = 7'b1111111;
      9:  seg_of = 7'b1111011;
      15: seg_of = 7'b0000000;
      default: seg_of = 7'b1010101;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input int d);
    if (d <= 9)       code_of = 4'(d);
    else if (d == 15) code_of = 4'hF;
    else              code_of = 4'hE;
  endfunction

  task automatic drive(input logic [3:0] dig, input logic [6:0] ol);
    @(negedge clk_16k);
    bus.DIG = dig;
    bus.OL  = ol;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 7'b0000000);
  endtask

  // One full scan, each digit held 'hold' cycles; optional ignored strobes after each digit.
  task automatic scan(input int d3, input int d2, input int d1, input int d0,
                      input int hold, input bit junk);
    int   ds[4];
    exp_t e;
    logic [3:0] strobe;
    ds[0] = d3; ds[1] = d2; ds[2] = d1; ds[3] = d0;
    for (int i = 0; i < 4; i++) begin
      strobe = 4'b1000 >> i;
      for (int h = 0; h < hold; h++) begin
        drive(strobe, seg_of(ds[i]));
        if (i == 3 && h == 0) begin
          e.bcd = {code_of(d3), code_of(d2), code_of(d1), code_of(d0)};
          e.ok  = (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9);
          if (e.ok) mdl_value = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
          e.value = 14'(mdl_value);
          e.cyc   = cyc + 3;
          sb_q.push_back(e);
        end
      end
      if (junk) begin
        drive(4'b0000, 7'($urandom));
        drive(4'b0011, 7'($urandom));
      end
    end
  endtask

  // Every frame_valid pulse must match the oldest predicted frame, at the predicted cycle.
  always @(negedge clk_16k) begin
    if (bus.frame_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_frame_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("frame_bcd", 32'(bus.bcd), 32'(e.bcd));
        chk("frame_value", 32'(bus.value), 32'(e.value));
        chk("frame_ok", 32'(bus.frame_ok), 32'(e.ok));
        chk("frame_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_bcd"},         32'(bus.bcd), 32'd0);
    chk({tag, "_value"},       32'(bus.value), 32'd0);
    chk({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
    chk({tag, "_frame_ok"},    32'(bus.frame_ok), 32'd0);
    chk({tag, "_seg_err"},     32'(bus.seg_err), 32'd0);
    chk({tag, "_seq_err"},     32'(bus.seq_err), 32'd0);
  endtask

  initial begin
    bus.DIG = 4'b0000;
    bus.OL  = 7'b0000000;
    rst     = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk_16k);
    check_all_zero("reset");

    // Good frame 0255, one digit per clock.
    scan(0, 2, 5, 5, 1, 1'b0);
    idle(4);
    chk("good_value_hold", 32'(bus.value), 32'd255);

    // Slow scan at maximum value, two scans back to back.
    scan(9, 9, 9, 9, 3, 1'b0);
    scan(9, 9, 9, 9, 3, 1'b0);
    idle(4);
    chk("slow_value", 32'(bus.value), 32'd9999);
    chk("slow_seq_err", 32'(bus.seq_err), 32'd0);

    // Back-to-back frames at minimum period.
    scan(1, 2, 3, 4, 1, 1'b0);
    scan(5, 6, 7, 8, 1, 1'b0);
    idle(4);

    // Illegal strobes between digits are ignored.
    scan(8, 0, 7, 1, 1, 1'b1);
    idle(4);
    chk("illegal_value", 32'(bus.value), 32'd8071);
    chk("illegal_seg_err", 32'(bus.seg_err), 32'd0);
    chk("illegal_seq_err", 32'(bus.seq_err), 32'd0);

    // Order violation: thousands then tens.
    drive(4'b1000, seg_of(1));
    drive(4'b0010, seg_of(2));
    idle(3);
    chk("order_seq_err", 32'(bus.seq_err), 32'd1);
    scan(0, 1, 2, 3, 1, 1'b0);
    idle(4);
    chk("order_value", 32'(bus.value), 32'd123);
    chk("order_seq_err_sticky", 32'(bus.seq_err), 32'd1);

    // Bad segment pattern on the tens digit.
    scan(4, 5, 14, 6, 1, 1'b0);
    idle(4);
    chk("badseg_seg_err", 32'(bus.seg_err), 32'd1);
    chk("badseg_value_held", 32'(bus.value), 32'd123);
    chk("badseg_tens", 32'(bus.bcd[7:4]), 32'hE);

    // Reset one cycle after the hundreds sample.
    drive(4'b1000, seg_of(3));
    drive(4'b0100, seg_of(3));
    @(negedge clk_16k);
    rst     = 1'b1;
    bus.DIG = 4'b0010;
    bus.OL  = seg_of(3);
    @(negedge clk_16k);
    rst     = 1'b0;
    mdl_value = 0;
    bus.DIG = 4'b0001;
    bus.OL  = seg_of(3);
    idle(4);
    check_all_zero("midreset");
    drive(4'b0001, seg_of(5));
    idle(5);
    chk("units_alone_no_frame", 32'(bus.frame_ok), 32'd0);
    scan(0, 0, 4, 2, 1, 1'b0);
    idle(4);
    chk("after_reset_value", 32'(bus.value), 32'd42);

    // Bounded drain of any outstanding predictions.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_16k);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
